pipeline_skid_register: RTL and testbench

Parametrised, general-purpose inter-stage pipeline register for the CPU pipeline. It replaces the fixed-field, always-advancing stage registers with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush. Stages can stall without combinational ready paths, and branch squashing can discard in-flight instructions. The payload is an opaque packed vector; the instantiating stage packs and unpacks its control and data fields.

---
 rtl/pipeline_skid_register.sv | 75 +++++++
 tb/tb_pipeline_skid_register.sv | 108 ++++++++++
 2 files changed

// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register: valid/ready stage register with 2-entry skid buffer and flush;
// define PIPE_SKID_STATS_EN to add saturating stall/bubble counters.
module pipeline_skid_register #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_count_o,
  output logic [CNT_WIDTH-1:0]  bubble_count_o
`endif
);
  // bit 0 is main_valid and bit 1 is skid_valid, so the handshake outputs are raw flop bits
  typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b11} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic accept, transfer;
  assign ready_o  = ~state_q[1];
  assign valid_o  = state_q[0];
  assign data_o   = main_q;
  assign accept   = valid_i && ready_o;
  assign transfer = valid_o && ready_i;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          main_d  = accept ? data_i : main_q;
          state_d = accept ? BUSY : EMPTY;
        end
        BUSY: begin
          main_d  = (accept && transfer) ? data_i : main_q;
          skid_d  = (accept && !transfer) ? data_i : skid_q;
          state_d = (accept && !transfer) ? FULL : (transfer && !accept) ? EMPTY : BUSY;
        end
        FULL: begin
          main_d  = transfer ? skid_q : main_q;
          state_d = transfer ? BUSY : FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    state_q <= reset_i ? EMPTY : state_d;
    main_q  <= main_d;
    skid_q  <= skid_d;
  end
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d, bubble_q, bubble_d;
  always_comb begin
    stall_d  = (valid_o && !ready_i && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    bubble_d = (!valid_o && ready_i && bubble_q != '1) ? bubble_q + 1'b1 : bubble_q;
  end
  always_ff @(posedge clk_i) begin
    stall_q  <= reset_i ? '0 : stall_d;
    bubble_q <= reset_i ? '0 : bubble_d;
  end
  assign stall_count_o  = stall_q;
  assign bubble_count_o = bubble_q;
`endif
endmodule

// File: tb/tb_pipeline_skid_register.sv
// tb_pipeline_skid_register: directed plan plus random traffic against a queue-based reference model.
module tb_pipeline_skid_register;
  localparam int DW = 8;
`ifdef PIPE_SKID_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int MAXC = (1 << CW) - 1;
  logic clk_i = 1'b0, reset_i, flush_i, valid_i, ready_i, ready_o, valid_o;
  logic [DW-1:0] data_i, data_o;
`ifdef PIPE_SKID_STATS_EN
  logic [CW-1:0] stall_count_o, bubble_count_o;
`endif
  int n_chk = 0, n_fail = 0, st = 0, bu = 0;
  logic [DW-1:0] q[$];
  pipeline_skid_register #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
`ifdef PIPE_SKID_STATS_EN
    , .stall_count_o(stall_count_o), .bubble_count_o(bubble_count_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic cyc(input logic rs, input logic f, input logic v, input logic [DW-1:0] d, input logic r);
    int sz;
    reset_i = rs; flush_i = f; valid_i = v; data_i = d; ready_i = r;
    @(posedge clk_i);
    sz = q.size();
    if (rs) begin
      q.delete(); st = 0; bu = 0;
    end else begin
      if (sz > 0 && !r && st < MAXC) st++;
      if (sz == 0 && r && bu < MAXC) bu++;
      if (f) q.delete();
      else begin
        if (sz > 0 && r) void'(q.pop_front());
        if (v && sz < 2) q.push_back(d);
      end
    end
    #1;
    chk("valid_o", 64'(valid_o), 64'(q.size() > 0));
    chk("ready_o", 64'(ready_o), 64'(q.size() < 2));
    if (q.size() > 0) chk("data_o", 64'(data_o), 64'(q[0]));
`ifdef PIPE_SKID_STATS_EN
    chk("stall_count", 64'(stall_count_o), 64'(st));
    chk("bubble_count", 64'(bubble_count_o), 64'(bu));
`endif
  endtask
  initial begin
    cyc(1, 0, 1, 8'h55, 1);
    cyc(1, 0, 1, 8'h55, 1);
    cyc(0, 0, 0, 8'h55, 0);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 8'(i), 1);
      chk("stream_data", 64'(data_o), 64'(i));
    end
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 8'h0A, 1);
    cyc(0, 0, 1, 8'h0B, 0);
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    chk("bp_hold_a", 64'(data_o), 64'h0A);
    cyc(0, 0, 1, 8'h0C, 0);
    chk("bp_still_a", 64'(data_o), 64'h0A);
    cyc(0, 0, 1, 8'h0C, 1);
    chk("bp_data_b", 64'(data_o), 64'h0B);
    chk("bp_ready_back", 64'(ready_o), 64'd1);
    cyc(0, 0, 1, 8'h0C, 1);
    chk("bp_data_c", 64'(data_o), 64'h0C);
    cyc(0, 0, 1, 8'h0A, 0);
    cyc(0, 0, 1, 8'h0B, 0);
    cyc(0, 1, 1, 8'h0C, 0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h0A, 1);
    cyc(0, 0, 1, 8'h10, 0);
    cyc(0, 0, 1, 8'h11, 1);
    chk("sim_data", 64'(data_o), 64'h11);
    chk("sim_valid", 64'(valid_o), 64'd1);
    chk("sim_ready", 64'(ready_o), 64'd1);
`ifdef PIPE_SKID_STATS_EN
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h21, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 0);
    chk("stall_5", 64'(stall_count_o), 64'd5);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 8'h00, 0);
    chk("stall_sat", 64'(stall_count_o), 64'd15);
    cyc(0, 1, 0, 8'h00, 0);
    chk("stall_flush", 64'(stall_count_o), 64'd15);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 1);
    chk("bubble_3", 64'(bubble_count_o), 64'd3);
`endif
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 70,
          8'($urandom), $urandom_range(99) < 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
